arm_pipeline: RTL and testbench
===============================

Name: arm_pipeline

Overview:
- Five-stage ARM-subset CPU control-path pipeline: IF, ID, EX, MEM, WB.
- Fetches 32-bit instructions from an internal 256-word instruction memory and decodes them into a control bundle in ID.
- Carries that bundle stage by stage through EX, MEM and WB registers.
- Top-level block under test for pipeline-control verification; no register file, ALU datapath or data memory inside.

Parameters:
- IMEM_DEPTH, 256, instruction memory words (8-bit word index)
- DATA_W, 32, instruction/PC width

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are named clk and reset.
- Required hierarchical names (bench access):
  - instr_mem.Mem[0:255], 32-bit; bench-writable; no reset of contents.
  - PC, 32-bit register.
  - instr_if_id, IF/ID instruction register.
  - control_unit with outputs ID_ALU_op[3:0], ID_AM[1:0], ID_B, ID_BL, ID_Load, RF_ENABLE, ID_MEM_SIZE, ID_MEM_WRITE.
  - EX_MEM, the ID→EX register, outputs EX_opcode[3:0], EX_am[1:0], EX_S, EX_Tload, EX_rf_e, EX_size, EX_rw, EX_e.
  - MEM_WB, the EX→MEM and MEM→WB registers, outputs MEM_Load, MEM_rf_e, MEM_size, MEM_rw, MEM_e, WB_rf_e.
- Reset (reset==0 at posedge): PC=0, instr_if_id=0, every EX_/MEM_/WB_ register=0. Reset mid-run flushes all stages on the same edge.
- IF:
  - Each non-reset edge: PC<=PC+4; instr_if_id<=Mem[PC[9:2]].
  - PC wraps modulo 2^32; the index wraps at 1024 bytes.
  - Internal enable is tied to 1; no stalls.
  - PC is purely sequential; branches are decoded but never redirect fetch.
- ID decode, combinational from instr_if_id:
  - instr==0: NOP, all controls 0.
  - DP ([27:26]=00):
    - ALU_op=[24:21]; S=[20].
    - AM=01 if I[25]=1, 00 if I=0 and [4]=0, 10 if [4]=1.
    - RF_ENABLE=1 unless opcode is 10xx (TST/TEQ/CMP/CMN).
  - LS ([27:26]=01):
    - ALU_op=0100 if U[23]=1, else 0010.
    - AM=10 if [25]=0 (immediate offset), 11 otherwise.
    - Load=[20]; MEM_SIZE=[22] (1=byte); MEM_WRITE=~[20]; RF_ENABLE=[20]; S=0.
  - Branch ([27:25]=101): B=1; BL=[24]; RF_ENABLE=[24]; ALU_op=0100; AM=00.
  - Any other encoding: all controls 0.
  - mem_e (internal) = LS.
- EX edge: EX_opcode<=ALU_op, EX_am<=AM, EX_S<=S, EX_Tload<=Load, EX_rf_e<=RF_ENABLE, EX_size<=MEM_SIZE, EX_rw<=MEM_WRITE, EX_e<=mem_e.
- MEM edge: MEM_Load<=EX_Tload, MEM_rf_e<=EX_rf_e, MEM_size<=EX_size, MEM_rw<=EX_rw, MEM_e<=EX_e.
- WB edge: WB_rf_e<=MEM_rf_e.
- Latency: an instruction at Mem[k] is in IF/ID after k+1 post-reset edges, in EX after k+2, in MEM after k+3, with WB_rf_e after k+4.
- No forwarding or hazard detection.

Decomposition:
- Shared package arm_pkg:
  - opcode constants (AND..MVN, 0000..1111);
  - AM encodings;
  - instruction-class field positions;
  - control-bundle struct.
- Natural sub-module: arm_control_unit (pure combinational decoder).
- Instruction memory and stage registers stay inline or as simple registers.

Test Plan:
- Hold reset=0 for 2 edges -> PC=0, all EX_/MEM_/WB_ =0. Release; after 1 edge PC=4 and instr_if_id=Mem[0].
- Mem[0]=0xE0821003 (ADD r1,r2,r3) -> ID: ALU_op=0100, AM=00, RF_ENABLE=1, S=0. Two edges later EX_opcode=0100 and EX_rf_e=1. WB_rf_e=1 after edge 4.
- Mem[0]=0xE2511001 (SUBS #1) -> ALU_op=0010, AM=01, S=1, RF_ENABLE=1. Mem[1]=0xE3510000 (CMP) -> ALU_op=1010, RF_ENABLE=0.
- Mem[0]=0xE5910004 (LDR) -> Load=1, AM=10, ALU_op=0100, MEM_WRITE=0, RF_ENABLE=1; MEM_Load=1 after 3 edges. Mem[1]=0xE5C10001 (STRB) -> MEM_SIZE=1, MEM_WRITE=1, EX_e=1, RF_ENABLE=0.
- Mem[0]=0xEB000002 (BL) -> B=1, BL=1, RF_ENABLE=1; PC continues 4,8,12 (no redirect).
- Zero-filled memory and mid-run reset=0 -> all-zero controls; the reset edge clears every stage register and PC regardless of in-flight instructions.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM-subset control-path pipeline: field positions,
// opcode and addressing-mode encodings, and the decoded control bundle.
package arm_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned IMEM_DEPTH = 256;
    localparam int unsigned IMEM_AW    = 8;

    // Data-processing opcodes, instr[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_RSC = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Addressing-mode encodings
    localparam logic [1:0] AM_DP_IMM_SHIFT = 2'b00;
    localparam logic [1:0] AM_DP_IMM       = 2'b01;
    localparam logic [1:0] AM_DP_REG_SHIFT = 2'b10;
    localparam logic [1:0] AM_LS_IMM       = 2'b10;
    localparam logic [1:0] AM_LS_REG       = 2'b11;

    // Instruction field positions
    localparam int unsigned CLS_HI     = 27;
    localparam int unsigned CLS_LO     = 26;
    localparam int unsigned BIT_I      = 25;
    localparam int unsigned BIT_LINK   = 24;
    localparam int unsigned OPC_HI     = 24;
    localparam int unsigned OPC_LO     = 21;
    localparam int unsigned BIT_U      = 23;
    localparam int unsigned BIT_BYTE   = 22;
    localparam int unsigned BIT_S      = 20;
    localparam int unsigned BIT_L      = 20;
    localparam int unsigned BIT_SHREG  = 4;

    localparam logic [1:0] CLS_DP     = 2'b00;
    localparam logic [1:0] CLS_LS     = 2'b01;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] am;
        logic       s;
        logic       b;
        logic       bl;
        logic       load;
        logic       rf_enable;
        logic       mem_size;
        logic       mem_write;
        logic       mem_e;
    } ctrl_t;

    // TST/TEQ/CMP/CMN only set flags and never write the register file
    function automatic logic is_compare_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/arm_control_unit.sv
// Combinational ID-stage decoder: instruction word to control bundle.
module arm_control_unit
    import arm_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [3:0]        ID_ALU_op,
    output logic [1:0]        ID_AM,
    output logic              ID_S,
    output logic              ID_B,
    output logic              ID_BL,
    output logic              ID_Load,
    output logic              RF_ENABLE,
    output logic              ID_MEM_SIZE,
    output logic              ID_MEM_WRITE,
    output logic              ID_mem_e
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        if (instr != '0) begin
            if (instr[CLS_HI:CLS_LO] == CLS_DP) begin
                ctrl.alu_op    = instr[OPC_HI:OPC_LO];
                ctrl.s         = instr[BIT_S];
                if (instr[BIT_I])
                    ctrl.am = AM_DP_IMM;
                else if (instr[BIT_SHREG])
                    ctrl.am = AM_DP_REG_SHIFT;
                else
                    ctrl.am = AM_DP_IMM_SHIFT;
                ctrl.rf_enable = !is_compare_op(instr[OPC_HI:OPC_LO]);
            end else if (instr[CLS_HI:CLS_LO] == CLS_LS) begin
                // Address generation: add offset when U is set, subtract otherwise
                ctrl.alu_op    = instr[BIT_U] ? OP_ADD : OP_SUB;
                ctrl.am        = instr[BIT_I] ? AM_LS_REG : AM_LS_IMM;
                ctrl.load      = instr[BIT_L];
                ctrl.mem_size  = instr[BIT_BYTE];
                ctrl.mem_write = !instr[BIT_L];
                ctrl.rf_enable = instr[BIT_L];
                ctrl.mem_e     = 1'b1;
            end else if (instr[CLS_HI:BIT_I] == CLS_BRANCH) begin
                ctrl.b         = 1'b1;
                ctrl.bl        = instr[BIT_LINK];
                ctrl.rf_enable = instr[BIT_LINK];
                ctrl.alu_op    = OP_ADD;
                ctrl.am        = AM_DP_IMM_SHIFT;
            end
        end
    end

    assign ID_ALU_op    = ctrl.alu_op;
    assign ID_AM        = ctrl.am;
    assign ID_S         = ctrl.s;
    assign ID_B         = ctrl.b;
    assign ID_BL        = ctrl.bl;
    assign ID_Load      = ctrl.load;
    assign RF_ENABLE    = ctrl.rf_enable;
    assign ID_MEM_SIZE  = ctrl.mem_size;
    assign ID_MEM_WRITE = ctrl.mem_write;
    assign ID_mem_e     = ctrl.mem_e;

endmodule

// File: rtl/arm_pipeline.sv
// Five-stage ARM-subset control pipeline: sequential fetch from an internal
// instruction memory, ID decode, and EX/MEM/WB control registers.
module arm_pipeline
    import arm_pkg::*;
(
    input logic clk,
    input logic reset
);

    logic [DATA_W-1:0] PC;
    logic [DATA_W-1:0] instr_if_id;

    // Contents are loaded by the environment; never reset
    if (1'b1) begin : instr_mem
        logic [DATA_W-1:0] Mem [0:IMEM_DEPTH-1];
    end

    // IF: fetch is strictly sequential, branches never redirect
    always_ff @(posedge clk) begin
        if (!reset) begin
            PC          <= '0;
            instr_if_id <= '0;
        end else begin
            PC          <= PC + DATA_W'(4);
            instr_if_id <= instr_mem.Mem[PC[IMEM_AW+1:2]];
        end
    end

    logic [3:0] ID_ALU_op;
    logic [1:0] ID_AM;
    logic       ID_S, ID_B, ID_BL, ID_Load, RF_ENABLE;
    logic       ID_MEM_SIZE, ID_MEM_WRITE, ID_mem_e;

    arm_control_unit control_unit (
        .instr        (instr_if_id),
        .ID_ALU_op    (ID_ALU_op),
        .ID_AM        (ID_AM),
        .ID_S         (ID_S),
        .ID_B         (ID_B),
        .ID_BL        (ID_BL),
        .ID_Load      (ID_Load),
        .RF_ENABLE    (RF_ENABLE),
        .ID_MEM_SIZE  (ID_MEM_SIZE),
        .ID_MEM_WRITE (ID_MEM_WRITE),
        .ID_mem_e     (ID_mem_e)
    );

    if (1'b1) begin : EX_MEM
        logic [3:0] EX_opcode;
        logic [1:0] EX_am;
        logic       EX_S, EX_Tload, EX_rf_e, EX_size, EX_rw, EX_e;

        always_ff @(posedge clk) begin
            if (!reset) begin
                EX_opcode <= '0;
                EX_am     <= '0;
                EX_S      <= 1'b0;
                EX_Tload  <= 1'b0;
                EX_rf_e   <= 1'b0;
                EX_size   <= 1'b0;
                EX_rw     <= 1'b0;
                EX_e      <= 1'b0;
            end else begin
                EX_opcode <= ID_ALU_op;
                EX_am     <= ID_AM;
                EX_S      <= ID_S;
                EX_Tload  <= ID_Load;
                EX_rf_e   <= RF_ENABLE;
                EX_size   <= ID_MEM_SIZE;
                EX_rw     <= ID_MEM_WRITE;
                EX_e      <= ID_mem_e;
            end
        end
    end

    if (1'b1) begin : MEM_WB
        logic MEM_Load, MEM_rf_e, MEM_size, MEM_rw, MEM_e, WB_rf_e;

        always_ff @(posedge clk) begin
            if (!reset) begin
                MEM_Load <= 1'b0;
                MEM_rf_e <= 1'b0;
                MEM_size <= 1'b0;
                MEM_rw   <= 1'b0;
                MEM_e    <= 1'b0;
                WB_rf_e  <= 1'b0;
            end else begin
                MEM_Load <= EX_MEM.EX_Tload;
                MEM_rf_e <= EX_MEM.EX_rf_e;
                MEM_size <= EX_MEM.EX_size;
                MEM_rw   <= EX_MEM.EX_rw;
                MEM_e    <= EX_MEM.EX_e;
                WB_rf_e  <= MEM_rf_e;
            end
        end
    end

    // Controls with no consumer inside this block; observed hierarchically only
    logic unused_ok;
    assign unused_ok = ^{ID_B, ID_BL, EX_MEM.EX_opcode, EX_MEM.EX_am, EX_MEM.EX_S,
                         MEM_WB.MEM_Load, MEM_WB.MEM_size, MEM_WB.MEM_rw,
                         MEM_WB.MEM_e, MEM_WB.WB_rf_e};

endmodule

// File: tb/tb_arm_pipeline.sv
// Self-checking bench for arm_pipeline: directed decode vectors, then random
// instruction images checked against a program-order reference model.
module tb_arm_pipeline;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arm_pipeline dut (
        .clk   (clk),
        .reset (reset)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] am;
        logic       s, b, bl, ld, rf, sz, wr, e;
    } ctl_t;

    int          checks = 0;
    int          errors = 0;
    int          n      = 0;
    logic [31:0] img  [0:255];
    logic [13:0] hand [0:5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, n);
        end
    endtask

    // Decode rules expressed on the raw word with plain arithmetic
    function automatic ctl_t ref_decode(input logic [31:0] w);
        ctl_t d = '0;
        int cls = int'(w >> 26) & 3;
        int op  = int'(w >> 21) & 15;
        if (w == 32'd0) return d;
        if (cls == 0) begin
            d.alu = 4'(op);
            d.s   = w[20];
            d.am  = w[25] ? 2'd1 : (w[4] ? 2'd2 : 2'd0);
            d.rf  = !(op >= 8 && op <= 11);
        end else if (cls == 1) begin
            d.alu = w[23] ? 4'd4 : 4'd2;
            d.am  = w[25] ? 2'd3 : 2'd2;
            d.ld  = w[20];
            d.sz  = w[22];
            d.wr  = !w[20];
            d.rf  = w[20];
            d.e   = 1'b1;
        end else if (((int'(w >> 25)) & 7) == 5) begin
            d.b   = 1'b1;
            d.bl  = w[24];
            d.rf  = w[24];
            d.alu = 4'd4;
        end
        return d;
    endfunction

    // Control bundle of the k-th fetched instruction; bubbles before the first
    function automatic ctl_t stage(input int k);
        if (k < 0) return '0;
        return ref_decode(img[8'(k)]);
    endfunction

    task automatic check_state(input string where);
        ctl_t id = stage(n - 1);
        ctl_t ex = stage(n - 2);
        ctl_t mm = stage(n - 3);
        ctl_t wb = stage(n - 4);
        check({where, ".pc"}, dut.PC, 32'(4 * n));
        check({where, ".ifid"}, dut.instr_if_id, (n >= 1) ? img[8'(n - 1)] : 32'd0);
        check({where, ".id"},
              32'({dut.control_unit.ID_ALU_op, dut.control_unit.ID_AM, dut.control_unit.ID_S,
                   dut.control_unit.ID_B, dut.control_unit.ID_BL, dut.control_unit.ID_Load,
                   dut.control_unit.RF_ENABLE, dut.control_unit.ID_MEM_SIZE,
                   dut.control_unit.ID_MEM_WRITE, dut.control_unit.ID_mem_e}),
              32'(id));
        check({where, ".ex"},
              32'({dut.EX_MEM.EX_opcode, dut.EX_MEM.EX_am, dut.EX_MEM.EX_S, dut.EX_MEM.EX_Tload,
                   dut.EX_MEM.EX_rf_e, dut.EX_MEM.EX_size, dut.EX_MEM.EX_rw, dut.EX_MEM.EX_e}),
              32'({ex.alu, ex.am, ex.s, ex.ld, ex.rf, ex.sz, ex.wr, ex.e}));
        check({where, ".mem"},
              32'({dut.MEM_WB.MEM_Load, dut.MEM_WB.MEM_rf_e, dut.MEM_WB.MEM_size,
                   dut.MEM_WB.MEM_rw, dut.MEM_WB.MEM_e}),
              32'({mm.ld, mm.rf, mm.sz, mm.wr, mm.e}));
        check({where, ".wb"}, 32'(dut.MEM_WB.WB_rf_e), 32'(wb.rf));
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        if (!reset) n = 0;
        else        n++;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 256; i++) dut.instr_mem.Mem[i] = img[i];
    endtask

    initial begin
        reset = 1'b0;

        // Directed image; hand-derived bundles {alu,am,s,b,bl,ld,rf,sz,wr,e}
        for (int i = 0; i < 256; i++) img[i] = 32'd0;
        img[0] = 32'hE082_1003;  hand[0] = 14'b0100_00_0_0_0_0_1_0_0_0; // ADD
        img[1] = 32'hE251_1001;  hand[1] = 14'b0010_01_1_0_0_0_1_0_0_0; // SUBS #1
        img[2] = 32'hE351_0000;  hand[2] = 14'b1010_01_1_0_0_0_0_0_0_0; // CMP #0
        img[3] = 32'hE591_0004;  hand[3] = 14'b0100_10_0_0_0_1_1_0_0_1; // LDR
        img[4] = 32'hE5C1_0001;  hand[4] = 14'b0100_10_0_0_0_0_0_1_1_1; // STRB
        img[5] = 32'hEB00_0002;  hand[5] = 14'b0100_00_0_1_1_0_1_0_0_0; // BL
        load_mem();

        clock_edge();
        clock_edge();
        check_state("rst");

        reset = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            clock_edge();
            check_state("dir");
            if (e <= 6)
                check($sformatf("dir.hand%0d", e - 1),
                      32'({dut.control_unit.ID_ALU_op, dut.control_unit.ID_AM,
                           dut.control_unit.ID_S, dut.control_unit.ID_B,
                           dut.control_unit.ID_BL, dut.control_unit.ID_Load,
                           dut.control_unit.RF_ENABLE, dut.control_unit.ID_MEM_SIZE,
                           dut.control_unit.ID_MEM_WRITE, dut.control_unit.ID_mem_e}),
                      32'(hand[e - 1]));
        end

        // Random image biased toward each instruction class
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 5))
                0:       img[i] = 32'd0;
                1:       img[i] = {4'hE, 2'b00, 26'($urandom)};
                2:       img[i] = {4'hE, 2'b01, 26'($urandom)};
                3:       img[i] = {4'hE, 3'b101, 25'($urandom)};
                default: img[i] = $urandom;
            endcase
        end
        load_mem();
        clock_edge();
        check_state("rst2");

        // Runs past the 1024-byte index wrap; one mid-run reset flushes in-flight work
        reset = 1'b1;
        for (int e = 1; e <= 700; e++) begin
            if (e == 300) reset = 1'b0;
            clock_edge();
            check_state((e == 300) ? "midrst" : "rnd");
            reset = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
